// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-master arbiter in front of port B of a data RAM. Master 0 is the hart,
// master 1 is the loader. Accesses are granted combinationally, one per
// cycle. Reads and out-of-range accesses return one cycle later, routed by a
// registered return tag. A master may lock the port for up to LOCK_MAX
// consecutive grants.
//
// Parameters
//   MEM_AW    RAM word-address window; an address is in range iff
//             addr[31:MEM_AW] == 0.
//   LOCK_MAX  maximum consecutive grants a locking master may hold.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   mN_req/op/addr/wdata/lock   master N request (op 01 read, 10 write)
//   mN_gnt                      request accepted this cycle (combinational)
//   mN_rvalid/rdata/err         response to master N, one cycle after grant
//   mem_addr/op/wdata           RAM port B command (op 00 = idle)
//   mem_rdata                   RAM read data, valid one cycle after a read
module dmem_arbiter #(
  parameter int MEM_AW   = 15,
  parameter int LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req,
  input  logic [1:0]  m0_op,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_lock,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic [1:0]  m1_op,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,

  output logic [31:0] mem_addr,
  output logic [1:0]  mem_op,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;
  localparam int         CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN0,
    ST_OWN1
  } state_t;

  // Captured at grant time; describes what comes back next cycle.
  typedef struct packed {
    logic owner;    // 0 = m0, 1 = m1
    logic is_read;
    logic is_err;
  } ret_tag_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;   // master granted most recently from IDLE
  ret_tag_t         tag_q, tag_d;

  // Op 00 and 11 are treated as no request at all.
  logic m0_valid, m1_valid;
  assign m0_valid = m0_req && (m0_op == OP_RD || m0_op == OP_WR);
  assign m1_valid = m1_req && (m1_op == OP_RD || m1_op == OP_WR);

  // Grant selection
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m0_valid && m1_valid) begin
          // Tie goes to whoever was not granted last.
          m0_gnt = last_q;
          m1_gnt = !last_q;
        end else begin
          m0_gnt = m0_valid;
          m1_gnt = m1_valid;
        end
      end
      ST_OWN0: m0_gnt = m0_valid;
      ST_OWN1: m1_gnt = m1_valid;
      default: ;
    endcase
    // Grants are combinational, so they must be masked explicitly in reset.
    if (rst) begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
    end
  end

  // Selected request (meaningful only when some grant is high)
  logic        any_gnt;
  logic [1:0]  s_op;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_lock;
  logic        in_range;

  assign any_gnt  = m0_gnt || m1_gnt;
  assign s_op     = m1_gnt ? m1_op    : m0_op;
  assign s_addr   = m1_gnt ? m1_addr  : m0_addr;
  assign s_wdata  = m1_gnt ? m1_wdata : m0_wdata;
  assign s_lock   = m1_gnt ? m1_lock  : m0_lock;
  assign in_range = (s_addr[31:MEM_AW] == '0);

  // RAM command: only granted in-range accesses reach the RAM.
  always_comb begin
    mem_op    = 2'b00;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (any_gnt && in_range) begin
      mem_op    = s_op;
      mem_addr  = s_addr;
      mem_wdata = s_wdata;
    end
  end

  // Next-state logic
  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    tag_d   = '0;

    if (any_gnt) begin
      tag_d.owner   = m1_gnt;
      tag_d.is_read = (s_op == OP_RD);
      tag_d.is_err  = !in_range;

      // Round-robin history only moves on arbitrated (IDLE) grants.
      if (state_q == ST_IDLE) begin
        last_d = m1_gnt;
      end

      // cnt_inc counts this grant, including the one that opened the lock,
      // so a locked run is at most LOCK_MAX grants long.
      if (s_lock && (cnt_inc < CNT_W'(LOCK_MAX))) begin
        state_d = m1_gnt ? ST_OWN1 : ST_OWN0;
        cnt_d   = cnt_inc;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else if (state_q != ST_IDLE) begin
      // Owner skipped a cycle: give up the lock.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;   // m0 wins the first tie
      tag_q   <= '0;     // drops any return still in flight
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers
      // sample their next value from the same pre-edge snapshot.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      tag_q   <= tag_d;
    end
  end

  // Response routing from the registered tag
  logic ret_active;
  assign ret_active = tag_q.is_read || tag_q.is_err;

  assign m0_rvalid = ret_active && !tag_q.owner;
  assign m1_rvalid = ret_active &&  tag_q.owner;
  assign m0_err    = m0_rvalid && tag_q.is_err;
  assign m1_err    = m1_rvalid && tag_q.is_err;
  assign m0_rdata  = (m0_rvalid && !tag_q.is_err) ? mem_rdata : 32'h0;
  assign m1_rdata  = (m1_rvalid && !tag_q.is_err) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. A small behavioural RAM sits on port B.
// Inputs change 1 time unit after the rising edge; outputs are compared on
// the falling edge.
module tb_dmem_arbiter;

  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;

  logic        clk = 1'b0;
  logic        rst;

  logic        m0_req, m0_lock, m0_gnt, m0_rvalid, m0_err;
  logic [1:0]  m0_op;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_lock, m1_gnt, m1_rvalid, m1_err;
  logic [1:0]  m1_op;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_op;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_op     (m0_op),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_lock   (m0_lock),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_op     (m1_op),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_lock   (m1_lock),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .mem_addr  (mem_addr),
    .mem_op    (mem_op),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Behavioural RAM: word-indexed, read data one cycle after the read op.
  logic [31:0] ram [0:8191];
  always @(posedge clk) begin
    if (rst) begin
      ram[13'h0004] = 32'h1111_0010;   // 0x10
      ram[13'h0008] = 32'h2222_0020;   // 0x20
      ram[13'h1FFF] = 32'hCAFE_7FFC;   // 0x7FFC
    end else if (mem_op == RD) begin
      mem_rdata <= ram[mem_addr[14:2]];
    end else if (mem_op == WR) begin
      ram[mem_addr[14:2]] = mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic drive0(input logic req, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic lock);
    m0_req = req; m0_op = op; m0_addr = addr; m0_wdata = wdata; m0_lock = lock;
  endtask

  task automatic drive1(input logic req, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic lock);
    m1_req = req; m1_op = op; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
  endtask

  task automatic idle_all();
    drive0(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    drive1(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    drive0(1'b1, RD, 32'h10, 32'h0, 1'b0);
    drive1(1'b1, RD, 32'h20, 32'h0, 1'b0);
    @(negedge clk);
    check_bit("rst_gnt0", m0_gnt, 1'b0);
    check_bit("rst_gnt1", m1_gnt, 1'b0);
    check("rst_mem_op", {30'b0, mem_op}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check_bit("rst_rvalid0", m0_rvalid, 1'b0);
    check_bit("rst_rvalid1", m1_rvalid, 1'b0);
    check("rst_rdata0", m0_rdata, 32'h0);
    next_cycle();
    rst = 1'b0;

    // ---------------- alternating round robin ----------------
    // Requests are still held from reset; first grant is in this cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_bit("rr_gnt0", m0_gnt, (i % 2) == 0);
      check_bit("rr_gnt1", m1_gnt, (i % 2) == 1);
      check("rr_mem_addr", mem_addr, (i % 2 == 0) ? 32'h10 : 32'h20);
      check("rr_mem_op", {30'b0, mem_op}, 32'h1);
      if (i > 0) begin
        if (i % 2 == 1) begin
          check_bit("rr_rvalid0", m0_rvalid, 1'b1);
          check("rr_rdata0", m0_rdata, 32'h1111_0010);
        end else begin
          check_bit("rr_rvalid1", m1_rvalid, 1'b1);
          check("rr_rdata1", m1_rdata, 32'h2222_0020);
        end
      end
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    check_bit("rr_tail_rvalid1", m1_rvalid, 1'b1);
    check("rr_tail_rdata1", m1_rdata, 32'h2222_0020);
    check_bit("rr_tail_rvalid0", m0_rvalid, 1'b0);
    next_cycle();

    // ---------------- m1 locked write stream ----------------
    drive1(1'b1, WR, 32'h100, 32'hA0, 1'b1);
    @(negedge clk);
    check_bit("lk_first_gnt1", m1_gnt, 1'b1);
    check("lk_first_op", {30'b0, mem_op}, 32'h2);
    check("lk_first_wdata", mem_wdata, 32'hA0);
    next_cycle();
    drive0(1'b1, RD, 32'h10, 32'h0, 1'b0);
    for (int k = 1; k < 8; k++) begin
      drive1(1'b1, WR, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k), 1'b1);
      @(negedge clk);
      check_bit("lk_gnt1", m1_gnt, 1'b1);
      check_bit("lk_gnt0_held", m0_gnt, 1'b0);
      check("lk_addr", mem_addr, 32'h100 + 32'(4 * k));
      check("lk_wdata", mem_wdata, 32'hA0 + 32'(k));
      check_bit("lk_no_rvalid1", m1_rvalid, 1'b0);
      next_cycle();
    end
    // Eight grants done: m1 must release, m0 wins.
    drive1(1'b1, WR, 32'h120, 32'hA8, 1'b1);
    @(negedge clk);
    check_bit("lk_max_gnt0", m0_gnt, 1'b1);
    check_bit("lk_max_gnt1", m1_gnt, 1'b0);
    check("lk_max_addr", mem_addr, 32'h10);
    next_cycle();
    drive0(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check_bit("lk_re_gnt1", m1_gnt, 1'b1);
    check("lk_re_wdata", mem_wdata, 32'hA8);
    check_bit("lk_re_rvalid0", m0_rvalid, 1'b1);
    check("lk_re_rdata0", m0_rdata, 32'h1111_0010);
    next_cycle();
    drive1(1'b1, WR, 32'h124, 32'hA9, 1'b1);
    @(negedge clk);
    check_bit("lk_own_gnt1", m1_gnt, 1'b1);
    next_cycle();
    // m1 still owns the port but goes quiet: m0 held off for one cycle.
    drive1(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    drive0(1'b1, RD, 32'h10, 32'h0, 1'b0);
    @(negedge clk);
    check_bit("lk_gap_gnt0", m0_gnt, 1'b0);
    check("lk_gap_op", {30'b0, mem_op}, 32'h0);
    next_cycle();
    @(negedge clk);
    check_bit("lk_after_gnt0", m0_gnt, 1'b1);
    next_cycle();
    idle_all();
    next_cycle();

    // ---------------- out-of-range accesses ----------------
    drive0(1'b1, RD, 32'h0000_8000, 32'h0, 1'b0);
    @(negedge clk);
    check_bit("oor_gnt0", m0_gnt, 1'b1);
    check("oor_op", {30'b0, mem_op}, 32'h0);
    check("oor_addr", mem_addr, 32'h0);
    next_cycle();
    drive0(1'b1, RD, 32'h0000_7FFC, 32'h0, 1'b0);
    @(negedge clk);
    check_bit("oor_rvalid0", m0_rvalid, 1'b1);
    check_bit("oor_err0", m0_err, 1'b1);
    check("oor_rdata0", m0_rdata, 32'h0);
    check("edge_op", {30'b0, mem_op}, 32'h1);
    check("edge_addr", mem_addr, 32'h0000_7FFC);
    next_cycle();
    drive0(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    drive1(1'b1, WR, 32'hFFFF_0000, 32'h55, 1'b0);
    @(negedge clk);
    check_bit("edge_rvalid0", m0_rvalid, 1'b1);
    check_bit("edge_err0", m0_err, 1'b0);
    check("edge_rdata0", m0_rdata, 32'hCAFE_7FFC);
    check_bit("oorw_gnt1", m1_gnt, 1'b1);
    check("oorw_op", {30'b0, mem_op}, 32'h0);
    check("oorw_wdata", mem_wdata, 32'h0);
    next_cycle();
    idle_all();
    @(negedge clk);
    check_bit("oorw_rvalid1", m1_rvalid, 1'b1);
    check_bit("oorw_err1", m1_err, 1'b1);
    check("oorw_rdata1", m1_rdata, 32'h0);
    check_bit("oorw_rvalid0", m0_rvalid, 1'b0);
    next_cycle();

    // ---------------- write then read back ----------------
    drive0(1'b1, WR, 32'h4, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check_bit("wr_gnt0", m0_gnt, 1'b1);
    check("wr_op", {30'b0, mem_op}, 32'h2);
    check("wr_addr", mem_addr, 32'h4);
    check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    drive0(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    drive1(1'b1, RD, 32'h4, 32'h0, 1'b0);
    @(negedge clk);
    check_bit("rb_gnt1", m1_gnt, 1'b1);
    check_bit("wr_no_rvalid0", m0_rvalid, 1'b0);
    next_cycle();
    idle_all();
    @(negedge clk);
    check_bit("rb_rvalid1", m1_rvalid, 1'b1);
    check("rb_rdata1", m1_rdata, 32'hDEAD_BEEF);
    check_bit("rb_err1", m1_err, 1'b0);
    check_bit("rb_rvalid0", m0_rvalid, 1'b0);
    next_cycle();

    // ---------------- op 11 / op 00 are not requests ----------------
    drive0(1'b1, 2'b11, 32'h10, 32'h0, 1'b0);
    @(negedge clk);
    check_bit("op11_gnt0", m0_gnt, 1'b0);
    check("op11_mem_op", {30'b0, mem_op}, 32'h0);
    next_cycle();
    drive1(1'b1, RD, 32'h20, 32'h0, 1'b0);
    @(negedge clk);
    check_bit("op11_other_gnt1", m1_gnt, 1'b1);
    check_bit("op11_other_gnt0", m0_gnt, 1'b0);
    check("op11_other_addr", mem_addr, 32'h20);
    next_cycle();
    drive0(1'b1, 2'b00, 32'h10, 32'h0, 1'b0);
    drive1(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check_bit("op00_gnt0", m0_gnt, 1'b0);
    check("op00_mem_op", {30'b0, mem_op}, 32'h0);
    next_cycle();
    idle_all();

    // ---------------- reset with a read in flight ----------------
    drive0(1'b1, RD, 32'h10, 32'h0, 1'b0);
    @(negedge clk);
    check_bit("mr_gnt0", m0_gnt, 1'b1);
    next_cycle();
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    check_bit("mr_rvalid0", m0_rvalid, 1'b0);
    check("mr_rdata0", m0_rdata, 32'h0);
    next_cycle();
    drive0(1'b1, RD, 32'h10, 32'h0, 1'b0);
    drive1(1'b1, RD, 32'h20, 32'h0, 1'b0);
    @(negedge clk);
    check_bit("mr_in_rst_gnt0", m0_gnt, 1'b0);
    check_bit("mr_in_rst_gnt1", m1_gnt, 1'b0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_bit("mr_post_gnt0", m0_gnt, 1'b1);
    check_bit("mr_post_gnt1", m1_gnt, 1'b0);
    check_bit("mr_post_rvalid0", m0_rvalid, 1'b0);
    next_cycle();
    @(negedge clk);
    check_bit("mr_next_gnt1", m1_gnt, 1'b1);
    check_bit("mr_next_rvalid0", m0_rvalid, 1'b1);
    check("mr_next_rdata0", m0_rdata, 32'h1111_0010);
    next_cycle();
    idle_all();
    next_cycle();

    // ---------------- lock released by lock=0 ----------------
    drive0(1'b1, RD, 32'h10, 32'h0, 1'b1);
    drive1(1'b1, RD, 32'h20, 32'h0, 1'b0);
    @(negedge clk);
    check_bit("l0_first_gnt0", m0_gnt, 1'b1);
    next_cycle();
    drive0(1'b1, RD, 32'h10, 32'h0, 1'b0);
    @(negedge clk);
    check_bit("l0_own_gnt0", m0_gnt, 1'b1);
    check_bit("l0_own_gnt1", m1_gnt, 1'b0);
    next_cycle();
    @(negedge clk);
    check_bit("l0_rel_gnt1", m1_gnt, 1'b1);
    check_bit("l0_rel_gnt0", m0_gnt, 1'b0);
    next_cycle();
    idle_all();
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
